spi_master: RTL and testbench
=============================

SPI_MASTER -- requirements
Module: spi_master

Interface
REQ-001 Parameter WIDTH, default 8, bits per transfer (min 2).
REQ-002 Parameter CLK_DIV, default 5, clk cycles per sck half-period (min 5, so F_SPI <= F_CLK/10).
REQ-003 Parameter CS_SETUP, default 5, clk cycles from ncs fall to the first sck half-period.
REQ-004 Parameter CS_IDLE, default 5, minimum clk cycles ncs stays high between transfers.
REQ-005 clk  in  1  sole clock; all logic on rising edge.
REQ-006 nrst  in  1  reset, asynchronous, active-low.
REQ-007 start  in  1  transfer request; accepted only in IDLE.
REQ-008 tx_data  in  WIDTH  word to send, MSB first.
REQ-009 last  in  1  burst terminator, sampled with start; present only with SPI_MASTER_BURST_EN.
REQ-010 busy  out  1  high from the cycle after acceptance until return to IDLE.
REQ-011 done  out  1  one-cycle pulse at word completion.
REQ-012 rx_data  out  WIDTH  received word, valid from the done pulse until the next done.
REQ-013 sck  out  1  SPI clock, mode 0 (idle low).
REQ-014 ncs  out  1  chip select, active-low.
REQ-015 mosi  out  1  serial data out.
REQ-016 miso  in  1  serial data in.

Function
REQ-017 FSM states: IDLE, SETUP, LOW, HIGH, HOLD, GAP, plus WAIT with burst; outputs registered.
REQ-018 IDLE: start=1 latches tx_data into the shift register, drives ncs=0 and mosi=tx_data[WIDTH-1], goes to SETUP; busy=1 next cycle.
REQ-019 SETUP: sck=0 for CS_SETUP cycles, then LOW.
REQ-020 LOW: sck=0 for CLK_DIV cycles; on exit sck goes to 1 and miso shifts into the receive register LSB in the same clk edge; then HIGH.
REQ-021 HIGH: sck=1 for CLK_DIV cycles; on exit sck goes to 0 and the bit counter increments.
REQ-022 On HIGH exit with fewer than WIDTH bits sent: mosi takes the next bit on the same edge as the sck fall; then LOW.
REQ-023 On HIGH exit after the WIDTH-th bit: go to HOLD.
REQ-024 HOLD: sck=0, ncs=0 for CLK_DIV cycles; then ncs=1, done=1 and rx_data updated on the same edge; then GAP.
REQ-025 GAP: ncs=1 for CS_IDLE cycles; busy falls on exit to IDLE.
REQ-026 Exactly WIDTH rising sck edges per word; sck period = 2*CLK_DIV clk cycles.
REQ-027 start while busy=1 is ignored; it is neither queued nor latched.
REQ-028 tx_data changes after acceptance do not affect the word in flight.
REQ-029 mosi holds its last value outside transfers.
REQ-030 Bit counter is ceil(log2(WIDTH+1)) bits wide and clears at acceptance; divider counter reloads on every state change.

Reset
REQ-031 nrst=0 immediately forces sck=0, ncs=1, mosi=0, busy=0, done=0, rx_data=0, state IDLE, all counters 0, including mid-transfer.
REQ-032 The first start is accepted no earlier than the first clk edge after nrst deasserts.

Configuration
REQ-033 Macro SPI_MASTER_BURST_EN.
- Defined: the last port exists.
- A start accepted with last=0 takes HOLD's exit to WAIT instead of GAP: ncs stays 0, sck=0, done pulses, busy=0.
- In WAIT, start latches a new word and goes directly to LOW with mosi=MSB; SETUP is skipped.
- A start accepted with last=1 ends that word with HOLD then GAP.
REQ-034 Not defined: the last port and the WAIT state are absent; every word ends with HOLD then GAP.

Verification
REQ-035 Defaults, tx_data=0xA5, miso tied to mosi -> 8 sck rising edges, period 10 clk, mosi 1,0,1,0,0,1,0,1, single done, rx_data=0xA5.
REQ-036 miso held 1 with tx_data=0x00 -> rx_data=0xFF; ncs fall to first sck rise = 10 clk; last sck fall to ncs rise = 5 clk.
REQ-037 start pulsed again 20 clk after acceptance with tx_data=0x3C -> ignored; one transfer of the original word, one done.
REQ-038 nrst low at bit 4 -> sck=0 and ncs=1 with no clk edge needed; after release, start with 0x81 -> clean full transfer, rx correct.
REQ-039 SPI_MASTER_BURST_EN, 0x12 with last=0 then 0x34 with last=1, loopback -> ncs low throughout, 16 rising edges, two done pulses, rx_data=0x12 then 0x34.

Source files
------------

// File: rtl/spi_master.sv
// SPI master, mode 0, MSB first, registered outputs and programmable chip-select timing.
// Define SPI_MASTER_BURST_EN to add the `last` port and the WAIT state for back-to-back words.
module spi_master #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CLK_DIV  = 5,
  parameter int unsigned CS_SETUP = 5,
  parameter int unsigned CS_IDLE  = 5
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             start,
  input  logic [WIDTH-1:0] tx_data,
`ifdef SPI_MASTER_BURST_EN
  input  logic             last,
`endif
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] rx_data,
  output logic             sck,
  output logic             ncs,
  output logic             mosi,
  input  logic             miso
);

  localparam int unsigned DivMax1 = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int unsigned DivMax  = (DivMax1 > CS_IDLE) ? DivMax1 : CS_IDLE;
  localparam int unsigned DivW    = (DivMax < 2) ? 1 : $clog2(DivMax);
  localparam int unsigned CntW    = $clog2(WIDTH + 1);

`ifdef SPI_MASTER_BURST_EN
  typedef enum logic [2:0] {
    StIdle, StSetup, StLow, StHigh, StHold, StGap, StWait
  } state_e;
`else
  typedef enum logic [2:0] {
    StIdle, StSetup, StLow, StHigh, StHold, StGap
  } state_e;
`endif

  state_e           state_q, state_d;
  logic [DivW-1:0]  div_q, div_d;
  logic [CntW-1:0]  bit_q, bit_d;
  // Holds only the bits not yet on mosi; the MSB goes straight to mosi at acceptance.
  logic [WIDTH-2:0] tx_sh_q, tx_sh_d;
  logic [WIDTH-1:0] rx_sh_q, rx_sh_d;
  logic [WIDTH-1:0] rx_data_q, rx_data_d;
  logic             sck_q, sck_d;
  logic             ncs_q, ncs_d;
  logic             mosi_q, mosi_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
`ifdef SPI_MASTER_BURST_EN
  logic             last_q, last_d;
`endif

  logic [31:0]      limit_m1;
  logic             div_end;

  // Each timed state lasts its configured cycle count, measured by div_q from 0.
  always_comb begin
    limit_m1 = 32'(CLK_DIV) - 32'd1;
    if (state_q == StSetup) begin
      limit_m1 = (CS_SETUP == 0) ? 32'd0 : 32'(CS_SETUP) - 32'd1;
    end else if (state_q == StGap) begin
      limit_m1 = (CS_IDLE == 0) ? 32'd0 : 32'(CS_IDLE) - 32'd1;
    end
    div_end = (32'(div_q) >= limit_m1);
  end

  always_comb begin
    state_d   = state_q;
    div_d     = div_q + DivW'(1);
    bit_d     = bit_q;
    tx_sh_d   = tx_sh_q;
    rx_sh_d   = rx_sh_q;
    rx_data_d = rx_data_q;
    sck_d     = sck_q;
    ncs_d     = ncs_q;
    mosi_d    = mosi_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef SPI_MASTER_BURST_EN
    last_d    = last_q;
`endif

    case (state_q)
      StIdle: begin
        div_d = '0;
        if (start) begin
          tx_sh_d = tx_data[WIDTH-2:0];
          mosi_d  = tx_data[WIDTH-1];
          ncs_d   = 1'b0;
          busy_d  = 1'b1;
          bit_d   = '0;
          state_d = StSetup;
`ifdef SPI_MASTER_BURST_EN
          last_d  = last;
`endif
        end
      end

      StSetup: begin
        if (div_end) begin
          div_d   = '0;
          state_d = StLow;
        end
      end

      StLow: begin
        if (div_end) begin
          div_d   = '0;
          sck_d   = 1'b1;
          rx_sh_d = {rx_sh_q[WIDTH-2:0], miso};
          state_d = StHigh;
        end
      end

      StHigh: begin
        if (div_end) begin
          div_d = '0;
          sck_d = 1'b0;
          bit_d = bit_q + CntW'(1);
          if (bit_q == CntW'(WIDTH - 1)) begin
            state_d = StHold;
          end else begin
            mosi_d  = tx_sh_q[WIDTH-2];
            tx_sh_d = tx_sh_q << 1;
            state_d = StLow;
          end
        end
      end

      StHold: begin
        if (div_end) begin
          div_d     = '0;
          done_d    = 1'b1;
          rx_data_d = rx_sh_q;
`ifdef SPI_MASTER_BURST_EN
          if (!last_q) begin
            // Keep the slave selected and wait for the next word of the burst.
            busy_d  = 1'b0;
            state_d = StWait;
          end else begin
            ncs_d   = 1'b1;
            state_d = StGap;
          end
`else
          ncs_d   = 1'b1;
          state_d = StGap;
`endif
        end
      end

      StGap: begin
        if (div_end) begin
          div_d   = '0;
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end

`ifdef SPI_MASTER_BURST_EN
      StWait: begin
        div_d = '0;
        if (start) begin
          tx_sh_d = tx_data[WIDTH-2:0];
          mosi_d  = tx_data[WIDTH-1];
          busy_d  = 1'b1;
          bit_d   = '0;
          last_d  = last;
          state_d = StLow;
        end
      end
`endif

      default: begin
        div_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_q   <= StIdle;
      div_q     <= '0;
      bit_q     <= '0;
      tx_sh_q   <= '0;
      rx_sh_q   <= '0;
      rx_data_q <= '0;
      sck_q     <= 1'b0;
      ncs_q     <= 1'b1;
      mosi_q    <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
`ifdef SPI_MASTER_BURST_EN
      last_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      div_q     <= div_d;
      bit_q     <= bit_d;
      tx_sh_q   <= tx_sh_d;
      rx_sh_q   <= rx_sh_d;
      rx_data_q <= rx_data_d;
      sck_q     <= sck_d;
      ncs_q     <= ncs_d;
      mosi_q    <= mosi_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
`ifdef SPI_MASTER_BURST_EN
      last_q    <= last_d;
`endif
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign sck     = sck_q;
  assign ncs     = ncs_q;
  assign mosi    = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Self-checking bench for spi_master: a negedge monitor logs the SPI bus and each scenario
// compares the log against words and timings derived from the transfer rules.
module tb_spi_master;

  localparam int unsigned W     = 8;
  localparam int unsigned DIV   = 5;
  localparam int unsigned SETUP = 5;
  localparam int unsigned IDLE  = 5;

  logic         clk = 1'b0;
  logic         nrst;
  logic         start;
  logic [W-1:0] tx_data;
`ifdef SPI_MASTER_BURST_EN
  logic         last;
`endif
  logic         busy, done, sck, ncs, mosi, miso;
  logic [W-1:0] rx_data;

  int checks   = 0;
  int failures = 0;

  spi_master #(
    .WIDTH    (W),
    .CLK_DIV  (DIV),
    .CS_SETUP (SETUP),
    .CS_IDLE  (IDLE)
  ) dut (
    .clk     (clk),
    .nrst    (nrst),
    .start   (start),
    .tx_data (tx_data),
`ifdef SPI_MASTER_BURST_EN
    .last    (last),
`endif
    .busy    (busy),
    .done    (done),
    .rx_data (rx_data),
    .sck     (sck),
    .ncs     (ncs),
    .mosi    (mosi),
    .miso    (miso)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Slave model: loopback, or a fixed pattern presented MSB first, one bit per sck rise.
  bit           miso_mode = 1'b0;
  logic [W-1:0] miso_pat  = '0;
  int           rise_in_word = 0;
  assign miso = miso_mode ? ((rise_in_word < int'(W)) ? miso_pat[W-1-rise_in_word] : 1'b0)
                          : mosi;

  int   rises[$];
  logic mosi_log[$];
  logic [W-1:0] rx_log[$];
  int   done_cnt = 0;
  int   ncs_rises = 0;
  int   stray_rises = 0;
  int   ncs_fall_cyc = 0;
  int   ncs_rise_cyc = 0;
  int   last_fall_cyc = 0;
  logic prev_sck = 1'b0;
  logic prev_ncs = 1'b1;

  always @(negedge clk) begin
    if (prev_ncs === 1'b1 && ncs === 1'b0) begin
      ncs_fall_cyc = cyc;
      rise_in_word = 0;
    end
    if (prev_ncs === 1'b0 && ncs === 1'b1) begin
      ncs_rise_cyc = cyc;
      ncs_rises++;
    end
    if (prev_sck === 1'b0 && sck === 1'b1) begin
      rises.push_back(cyc);
      mosi_log.push_back(mosi);
      rise_in_word++;
      if (ncs !== 1'b0) stray_rises++;
    end
    if (prev_sck === 1'b1 && sck === 1'b0) last_fall_cyc = cyc;
    if (done === 1'b1) begin
      done_cnt++;
      rx_log.push_back(rx_data);
      rise_in_word = 0;
    end
    prev_sck = sck;
    prev_ncs = ncs;
  end

  task automatic run_word(input logic [W-1:0] word, input bit pat_mode, input logic [W-1:0] pat,
                          input bit last_bit, input bit fresh, input bit ends, input bit poke);
    int r0, m0, d0, x0, acc_cyc, bad, n;
    logic [W-1:0] got, exp_rx;
    r0 = rises.size();
    m0 = mosi_log.size();
    d0 = done_cnt;
    x0 = rx_log.size();
    exp_rx = pat_mode ? pat : word;
    miso_mode = pat_mode;
    miso_pat  = pat;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_before_start: got %b want 0", busy);
    end
    tx_data = word;
    start   = 1'b1;
`ifdef SPI_MASTER_BURST_EN
    last    = last_bit;
`endif
    @(negedge clk);
    acc_cyc = cyc;
    start   = 1'b0;
    tx_data = W'($urandom);
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL busy_after_accept: got %b want 1", busy);
    end
    if (poke) begin
      repeat (19) @(negedge clk);
      tx_data = W'(8'h3C);
      start   = 1'b1;
      @(negedge clk);
      start   = 1'b0;
    end
    for (int i = 0; i < 1000 && done_cnt == d0; i++) @(negedge clk);
    checks++;
    if (done_cnt == d0) begin
      failures++;
      $display("FAIL done_timeout: got no done want one within 1000 cycles");
    end
    @(negedge clk);
    if (ends) begin
      for (int i = 0; i < 100 && busy !== 1'b0; i++) @(negedge clk);
      checks++;
      if (busy !== 1'b0 || ncs !== 1'b1) begin
        failures++;
        $display("FAIL end_idle: got busy=%b ncs=%b want busy=0 ncs=1", busy, ncs);
      end
      checks++;
      if (ncs_rise_cyc - last_fall_cyc != int'(DIV)) begin
        failures++;
        $display("FAIL sck_fall_to_ncs_rise: got %0d want %0d", ncs_rise_cyc - last_fall_cyc, DIV);
      end
    end else begin
      checks++;
      if (busy !== 1'b0 || ncs !== 1'b0 || sck !== 1'b0) begin
        failures++;
        $display("FAIL burst_wait: got busy=%b ncs=%b sck=%b want 0 0 0", busy, ncs, sck);
      end
    end
    n = rises.size() - r0;
    checks++;
    if (n != int'(W)) begin
      failures++;
      $display("FAIL sck_rise_count: got %0d want %0d", n, W);
    end
    got = '0;
    for (int i = 0; i < int'(W) && m0 + i < mosi_log.size(); i++) got = {got[W-2:0], mosi_log[m0+i]};
    checks++;
    if (got !== word) begin
      failures++;
      $display("FAIL mosi_bits: got %h want %h", got, word);
    end
    bad = 0;
    for (int i = 1; i < n; i++) if (rises[r0+i] - rises[r0+i-1] != int'(2 * DIV)) bad++;
    checks++;
    if (bad != 0) begin
      failures++;
      $display("FAIL sck_period: got %0d bad periods want 0", bad);
    end
    if (n > 0) begin
      checks++;
      if (rises[r0] - acc_cyc != int'(fresh ? SETUP + DIV : DIV)) begin
        failures++;
        $display("FAIL first_rise_delay: got %0d want %0d", rises[r0] - acc_cyc,
                 fresh ? SETUP + DIV : DIV);
      end
    end
    if (fresh) begin
      checks++;
      if (ncs_fall_cyc != acc_cyc) begin
        failures++;
        $display("FAIL ncs_fall_at_accept: got cycle %0d want %0d", ncs_fall_cyc, acc_cyc);
      end
    end
    checks++;
    if (rx_log.size() <= x0 || rx_log[x0] !== exp_rx) begin
      failures++;
      $display("FAIL rx_at_done: got %h want %h", (rx_log.size() > x0) ? rx_log[x0] : 'x, exp_rx);
    end
    checks++;
    if (rx_data !== exp_rx) begin
      failures++;
      $display("FAIL rx_held: got %h want %h", rx_data, exp_rx);
    end
    checks++;
    if (done_cnt - d0 != 1) begin
      failures++;
      $display("FAIL done_count: got %0d want 1", done_cnt - d0);
    end
  endtask

  task automatic test_reset();
    nrst    = 1'b0;
    start   = 1'b0;
    tx_data = '0;
`ifdef SPI_MASTER_BURST_EN
    last    = 1'b1;
`endif
    repeat (3) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    checks++;
    if (sck !== 1'b0 || ncs !== 1'b1 || mosi !== 1'b0 || busy !== 1'b0 || done !== 1'b0
        || rx_data !== '0) begin
      failures++;
      $display("FAIL reset_state: got sck=%b ncs=%b mosi=%b busy=%b done=%b rx=%h want 0 1 0 0 0 00",
               sck, ncs, mosi, busy, done, rx_data);
    end
    start = 1'b0;
    nrst  = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || ncs !== 1'b1) begin
      failures++;
      $display("FAIL start_in_reset: got busy=%b ncs=%b want 0 1", busy, ncs);
    end
  endtask

  task automatic test_ignored_start();
    int d0;
    run_word(W'(8'h96), 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b1);
    d0 = done_cnt;
    repeat (40) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || ncs !== 1'b1) begin
      failures++;
      $display("FAIL ignored_start_queued: got extra done=%0d busy=%b ncs=%b want 0 0 1",
               done_cnt - d0, busy, ncs);
    end
  endtask

  task automatic test_reset_mid_transfer();
    int r0;
    r0 = rises.size();
    miso_mode = 1'b0;
    @(negedge clk);
    tx_data = W'(8'hC3);
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 500 && rises.size() - r0 < 4; i++) @(negedge clk);
    repeat (DIV + 2) @(negedge clk);
    #2 nrst = 1'b0;
    #1;
    checks++;
    if (sck !== 1'b0 || ncs !== 1'b1 || busy !== 1'b0 || mosi !== 1'b0 || done !== 1'b0
        || rx_data !== '0) begin
      failures++;
      $display("FAIL async_reset: got sck=%b ncs=%b busy=%b mosi=%b done=%b rx=%h want 0 1 0 0 0 00",
               sck, ncs, busy, mosi, done, rx_data);
    end
    @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
    run_word(W'(8'h81), 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic [W-1:0] word, pat;
    bit pm;
    for (int k = 0; k < 6; k++) begin
      word = W'($urandom);
      pat  = W'($urandom);
      pm   = 1'($urandom_range(0, 1));
      run_word(word, pm, pat, 1'b1, 1'b1, 1'b1, 1'b0);
    end
  endtask

`ifdef SPI_MASTER_BURST_EN
  task automatic test_back_to_back();
    int r0, n0;
    r0 = rises.size();
    n0 = ncs_rises;
    run_word(W'(8'h12), 1'b0, '0, 1'b0, 1'b1, 1'b0, 1'b0);
    run_word(W'(8'h34), 1'b0, '0, 1'b1, 1'b0, 1'b1, 1'b0);
    checks++;
    if (rises.size() - r0 != 2 * int'(W) || ncs_rises - n0 != 1) begin
      failures++;
      $display("FAIL burst_frame: got rises=%0d ncs_rises=%0d want %0d 1",
               rises.size() - r0, ncs_rises - n0, 2 * W);
    end
  endtask
`endif

  initial begin
    test_reset();
    run_word(W'(8'hA5), 1'b0, '0, 1'b1, 1'b1, 1'b1, 1'b0);
    run_word(W'(8'h00), 1'b1, W'(8'hFF), 1'b1, 1'b1, 1'b1, 1'b0);
    test_ignored_start();
    test_reset_mid_transfer();
    test_random();
`ifdef SPI_MASTER_BURST_EN
    test_back_to_back();
`endif
    checks++;
    if (stray_rises != 0) begin
      failures++;
      $display("FAIL sck_outside_ncs: got %0d rises want 0", stray_rises);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
